// File: rtl/stream_mcast_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mcast_pkg
// Description : Shared helpers for the multicast stream scheduler. Provides
//               the credit counter width function and the default credit
//               counter type.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_mcast_pkg;

    // A counter that must hold the values 0..credits needs clog2(credits+1)
    // bits; never return zero so a degenerate depth still elaborates cleanly.
    function automatic int unsigned cnt_width(input int unsigned credits);
        return (credits < 1) ? 1 : $clog2(credits + 1);
    endfunction

    localparam int unsigned c_default_credits = 4;
    localparam int unsigned c_default_cnt_w   = cnt_width(c_default_credits);

    typedef logic [c_default_cnt_w-1:0] credit_cnt_t;

endpackage : stream_mcast_pkg
`default_nettype wire

// File: rtl/stream_mcast_credit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : stream_mcast_credit_cnt
// Description : Per-output credit counter. Tracks free slots in one output's
//               downstream buffer. Decrements on a consumed beat, increments
//               on a returned credit and saturates at CREDITS.
// Ports       : clk_i, rst_i, clr_i   - clock, sync reset, sync clear
//               consume_i             - a beat was handshaked on this output
//               return_i              - downstream freed one slot
//               avail_o               - at least one credit held
//               count_o               - current credit count
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mcast_credit_cnt
    import stream_mcast_pkg::*;
#(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CNT_W   = cnt_width(CREDITS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             consume_i,
    input  logic             return_i,
    output logic             avail_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(CREDITS);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // consume_i can only be high while credit is held, so no underflow guard
    // is needed; a return into a full counter is dropped (saturation).
    always_comb begin
        count_d = count_q;
        if (consume_i && !return_i) begin
            count_d = count_q - CNT_W'(1);
        end else if (return_i && !consume_i && (count_q != c_max)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= c_max;
        end else begin
            count_q <= count_d;
        end
    end

    assign avail_o = (count_q != '0);
    assign count_o = count_q;

    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
        !(return_i && !consume_i && (count_q == c_max)))
        else $error("credit returned while counter already full");

endmodule : stream_mcast_credit_cnt
`default_nettype wire

// File: rtl/stream_mcast_sched.sv
`default_nettype none
// ============================================================================
// Module      : stream_mcast_sched
// Description : Multicast scheduler for a ready/valid stream. Each input beat
//               is delivered once to every output in its destination mask and
//               acknowledged upstream only when all of them have handshaked.
//               Each output is gated by its own credit counter.
// Ports       : clk_i, rst_i, clr_i   - clock, sync reset, sync clear
//               valid_i / ready_o     - input beat handshake
//               sel_i                 - destination mask of the current beat
//               valid_o / ready_i     - per-output handshake
//               credit_i              - per-output credit return pulse
//               busy_o                - beat partially delivered
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mcast_sched
    import stream_mcast_pkg::*;
#(
    parameter int unsigned N_OUP   = 2,
    parameter int unsigned CREDITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [N_OUP-1:0] sel_i,
    output logic [N_OUP-1:0] valid_o,
    input  logic [N_OUP-1:0] ready_i,
    input  logic [N_OUP-1:0] credit_i,
    output logic             busy_o
);

    localparam int unsigned c_cnt_w = cnt_width(CREDITS);

    if (N_OUP < 1) begin : g_chk_n_oup
        $error("N_OUP must be at least 1");
    end
    if (CREDITS < 1) begin : g_chk_credits
        $error("CREDITS must be at least 1");
    end

    // done_q[i] is the per-output state: 0 = still pending, 1 = served.
    logic [N_OUP-1:0] done_q;
    logic [N_OUP-1:0] done_d;

    logic [N_OUP-1:0] w_pending;
    logic [N_OUP-1:0] w_avail;
    logic [N_OUP-1:0] w_valid;
    logic [N_OUP-1:0] w_hs;
    logic             w_flush;
    logic             w_ready;
    logic             w_in_hs;
    logic [c_cnt_w-1:0] w_count [N_OUP];

    assign w_flush   = rst_i | clr_i;
    assign w_pending = sel_i & ~done_q;
    assign w_valid   = {N_OUP{valid_i & ~w_flush}} & w_pending & w_avail;
    assign w_hs      = w_valid & ready_i;
    // Accept once nothing selected is left without a handshake this cycle;
    // an empty mask therefore accepts (drops) the beat immediately.
    assign w_ready   = valid_i & ~w_flush & ((w_pending & ~w_hs) == '0);
    assign w_in_hs   = valid_i & w_ready;

    always_comb begin
        done_d = done_q | w_hs;
        if (w_in_hs) begin
            done_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    assign valid_o = w_valid;
    assign ready_o = w_ready;
    assign busy_o  = |done_q;

    for (genvar g = 0; g < N_OUP; g++) begin : g_credit
        stream_mcast_credit_cnt #(
            .CREDITS (CREDITS),
            .CNT_W   (c_cnt_w)
        ) u_credit_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .clr_i     (clr_i),
            .consume_i (w_hs[g]),
            .return_i  (credit_i[g]),
            .avail_o   (w_avail[g]),
            .count_o   (w_count[g])
        );

        a_count_bound : assert property (@(posedge clk_i) disable iff (w_flush)
            w_count[g] <= c_cnt_w'(CREDITS))
            else $error("credit counter above its depth");
    end

    a_in_stable : assert property (@(posedge clk_i) disable iff (w_flush)
        (valid_i && !ready_o) |=> (valid_i && $stable(sel_i)))
        else $error("valid_i/sel_i changed before input handshake");

endmodule : stream_mcast_sched
`default_nettype wire
